multicycle_controller: RTL and testbench

//  Control unit driving the multicycle RV32I datapath: Moore FSM plus ALU decoder.

---
 rtl/multicycle_controller_pkg.sv | 60 ++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 157 +++++++++++++++
 tb/tb_multicycle_controller.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM state encoding,
// opcode constants, ALU operation classes, alu_ctrl codes and datapath mux
// select codes.
// Build option: CTRL_ILLEGAL_TRAP_EN adds the HALT state used for illegal opcodes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,S_HALT    = 4'd11
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath connection bundle.
//   master: controller side (reads instruction fields and zero, drives controls)
//   slave : datapath side
// Fields: opcode/funct3/funct7b5/zero from the datapath; pc_write, adr_src,
// mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src, reg_write,
// alu_ctrl, illegal_insn to the datapath.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_ctrl;
    logic       illegal_insn;

    modport master (
        input  opcode, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_ctrl, illegal_insn
    );

    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_ctrl, illegal_insn
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus instruction
// fields to the 3-bit alu_ctrl code.
// Ports: alu_op (class), funct3, op5 (opcode[5]), funct7b5 -> alu_ctrl.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type so addi never becomes sub
                    3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM, output decode, imm_src decode and
// ALU decoder instance.
// Ports: clk, reset (synchronous, active high), bus (master modport of
// multicycle_controller_if carrying instruction fields in, controls out).
// Build option: CTRL_ILLEGAL_TRAP_EN -- unsupported opcodes park the FSM in HALT
// and raise illegal_insn until reset; otherwise they execute as a nop.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | compute branch target, dispatch on opcode
// MEMADR   | effective address for lw/sw
// MEMREAD  | read data memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write data memory
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALU result to rd
// BEQ      | compare, take branch if zero
// JAL      | PC <= target, compute return address
// HALT     | illegal opcode trap (CTRL_ILLEGAL_TRAP_EN only)
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);
    state_t  state, state_next, state_eff;
    alu_op_t alu_op;
    logic    pc_update, branch, mem_write_i, ir_write_i, reg_write_i;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // During reset the selects show FETCH values; enables are gated below.
    assign state_eff = reset ? S_FETCH : state;

    always_comb begin
        state_next     = state;
        pc_update      = 1'b0;
        branch         = 1'b0;
        mem_write_i    = 1'b0;
        ir_write_i     = 1'b0;
        reg_write_i    = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RD2;
        alu_op         = ALUOP_ADD;
        case (state_eff)
            S_FETCH: begin
                ir_write_i     = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURESULT;
                pc_update      = 1'b1;
                state_next     = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           state_next = S_HALT;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
                state_next    = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                state_next  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                reg_write_i    = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write_i = 1'b1;
                state_next  = S_FETCH;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RD1;
                alu_op        = ALUOP_FUNCT;
                state_next    = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
                state_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_i = 1'b1;
                state_next  = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = SRCA_RD1;
                alu_op        = ALUOP_SUB;
                branch        = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_update     = 1'b1;
                state_next    = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_FETCH;
        endcase
    end

    assign bus.pc_write  = !reset && (pc_update || (branch && bus.zero));
    assign bus.mem_write = !reset && mem_write_i;
    assign bus.ir_write  = !reset && ir_write_i;
    assign bus.reg_write = !reset && reg_write_i;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_insn = !reset && (state == S_HALT);
`else
    assign bus.illegal_insn = 1'b0;
`endif

    always_comb begin
        bus.imm_src = IMM_I;
        case (bus.opcode)
            OP_STORE:  bus.imm_src = IMM_S;
            OP_BRANCH: bus.imm_src = IMM_B;
            OP_JAL:    bus.imm_src = IMM_J;
            default:   bus.imm_src = IMM_I;
        endcase
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (bus.funct3),
        .op5      (bus.opcode[5]),
        .funct7b5 (bus.funct7b5),
        .alu_ctrl (bus.alu_ctrl)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction pushes
// its expected per-cycle control vectors; a negedge monitor pops and compares.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, imm_src, reg_write, alu_ctrl, illegal_insn}
    logic [16:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [2:0] alu_ref(logic [6:0] op, logic [2:0] f3, logic f7);
        if (op == 7'b0110011 || op == 7'b0010011) begin
            case (f3)
                3'b000:  return (op == 7'b0110011 && f7) ? 3'b110 : 3'b010;
                3'b010:  return 3'b111;
                3'b110:  return 3'b001;
                3'b111:  return 3'b000;
                default: return 3'b010;
            endcase
        end
        return 3'b010;
    endfunction

    function automatic logic [1:0] imm_ref(logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic push(string tag, bit pcw, bit adr, bit mw, bit irw, logic [1:0] res,
                        logic [1:0] a, logic [1:0] b, bit rw, logic [2:0] alu, bit ill);
        exp_q.push_back({pcw, adr, mw, irw, res, a, b, imm_ref(bus.opcode), rw, alu, ill});
        tag_q.push_back(tag);
    endtask

    task automatic push_reset();
        push("reset", 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b010, 0);
    endtask

    always @(negedge clk) begin
        logic [16:0] e, act;
        string       t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                   bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.reg_write, bus.alu_ctrl,
                   bus.illegal_insn};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s op=%b f3=%b: got %b expected %b", t, bus.opcode, bus.funct3, act, e);
            end
        end
    end

    // Issues one instruction starting in FETCH; returns after its last cycle.
    task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f7, logic z);
        int n;
        logic [2:0] af;
        bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        af = alu_ref(op, f3, f7);
        push("fetch",  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b010, 0);
        push("decode", 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b010, 0);
        n = 2;
        case (op)
            7'b0000011: begin
                push("memadr",  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0);
                push("memread", 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0);
                push("memwb",   0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b010, 0);
                n += 3;
            end
            7'b0100011: begin
                push("memadr",   0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0);
                push("memwrite", 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 0);
                n += 2;
            end
            7'b0110011: begin
                push("execr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, af, 0);
                push("aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0);
                n += 2;
            end
            7'b0010011: begin
                push("execi", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, af, 0);
                push("aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0);
                n += 2;
            end
            7'b1100011: begin
                push("beq", z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b110, 0);
                n += 1;
            end
            7'b1101111: begin
                push("jal",   1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b010, 0);
                push("aluwb", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0);
                n += 2;
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) begin
                    push("halt", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b010, 1);
                    n++;
                end
`endif
            end
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [6:0] legal_ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                 7'b0010011, 7'b1100011, 7'b1101111};

    initial begin
        int k;
        reset = 1'b1;
        bus.opcode = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        @(posedge clk); #1;
        repeat (3) push_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b1);
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b1);

        // sw interrupted by reset while in MEMWRITE
        bus.opcode = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
        push("fetch",  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b010, 0);
        push("decode", 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b010, 0);
        push("memadr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b010, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        push_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            k = int'($urandom_range(0, 5));
            run_instr(legal_ops[k], 3'($urandom), 1'($urandom), 1'($urandom));
`else
            k = int'($urandom_range(0, 7));
            if (k == 6)      run_instr(7'b1111111, 3'($urandom), 1'($urandom), 1'($urandom));
            else if (k == 7) run_instr(7'b0000000, 3'($urandom), 1'($urandom), 1'($urandom));
            else             run_instr(legal_ops[k], 3'($urandom), 1'($urandom), 1'($urandom));
`endif
        end

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        reset = 1'b1;
        push_reset();
        @(posedge clk);
        #1 reset = 1'b0;
`endif
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
